lfsr_burst_ctrl: RTL and testbench

Sequencer for the team's 16-bit Fibonacci LFSR pattern source. The block contains the LFSR state register and controls it.
- On a start request it loads a seed and emits a programmed number of pseudo-random words over a valid/ready stream.
- It then returns to idle and reports completion.
- Test-pattern generators and scramblers use it to get bounded, reproducible PRBS bursts instead of a free-running LFSR.

---
 rtl/lfsr_burst_ctrl_if.sv | 49 ++++
 rtl/lfsr_burst_ctrl.sv | 115 +++++++++++
 tb/tb_lfsr_burst_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_burst_ctrl_if.sv
// ============================================================================
// Module      : lfsr_burst_ctrl_if
// Description : Control and stream bundle for lfsr_burst_ctrl.
//               master : requester / downstream consumer (drives start,
//                        seed, burst_len, out_ready and optionally abort)
//               slave  : the burst controller itself
// Ports       : start, seed[15:0], burst_len[LEN_W-1:0], out_ready,
//               out_valid, lfsr_out[15:0], busy, done, words_left[LEN_W-1:0],
//               abort (only when LFSR_BURST_CTRL_ABORT_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lfsr_burst_ctrl_if #(
    parameter int LEN_W = 8
) ();
    logic             start;
    logic [15:0]      seed;
    logic [LEN_W-1:0] burst_len;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      lfsr_out;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] words_left;
`ifdef LFSR_BURST_CTRL_ABORT_EN
    logic             abort;

    modport master (
        output start, seed, burst_len, out_ready, abort,
        input  out_valid, lfsr_out, busy, done, words_left
    );
    modport slave (
        input  start, seed, burst_len, out_ready, abort,
        output out_valid, lfsr_out, busy, done, words_left
    );
`else
    modport master (
        output start, seed, burst_len, out_ready,
        input  out_valid, lfsr_out, busy, done, words_left
    );
    modport slave (
        input  start, seed, burst_len, out_ready,
        output out_valid, lfsr_out, busy, done, words_left
    );
`endif
endinterface

`default_nettype wire

// File: rtl/lfsr_burst_ctrl.sv
// ============================================================================
// Module      : lfsr_burst_ctrl
// Description : Burst sequencer around a 16-bit Fibonacci LFSR
//               (x^16+x^14+x^13+x^11+1). A start request loads a seed and
//               emits burst_len pseudo-random words on a valid/ready stream,
//               then pulses done and returns to idle.
// Ports       : clk      - system clock, rising edge
//               reset_n  - synchronous active-low reset
//               bus      - lfsr_burst_ctrl_if.slave (start/seed/burst_len in,
//                          out_valid/lfsr_out/out_ready stream, busy, done,
//                          words_left status)
// Options     : LFSR_BURST_CTRL_ABORT_EN - adds bus.abort to cut a burst
//               short from LOAD or RUN (done still pulses).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_burst_ctrl #(
    parameter int          LEN_W        = 8,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset_n,
    lfsr_burst_ctrl_if.slave bus
);
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [LEN_W-1:0] c_one = LEN_W'(1);

    logic [1:0]       r_state;
    logic [15:0]      r_lfsr;
    logic [LEN_W-1:0] r_words_left;

    logic             w_fb;
    logic [15:0]      w_lfsr_next;
    logic [15:0]      w_seed_eff;
    logic             w_handshake;
    logic             w_abort;

    assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsr_next = {r_lfsr[14:0], w_fb};

    // An all-zero seed would lock the LFSR, so substitute the default.
    assign w_seed_eff  = (bus.seed == 16'h0000) ? DEFAULT_SEED : bus.seed;

    assign w_handshake = (r_state == c_st_run) && bus.out_ready;

`ifdef LFSR_BURST_CTRL_ABORT_EN
    assign w_abort = bus.abort && ((r_state == c_st_load) || (r_state == c_st_run));
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= c_st_idle;
            r_lfsr       <= 16'h0000;
            r_words_left <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        if (bus.burst_len != '0) begin
                            r_state      <= c_st_load;
                            r_lfsr       <= w_seed_eff;
                            r_words_left <= bus.burst_len;
                        end else begin
                            // Empty burst: report completion, leave LFSR alone.
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_load: begin
                    r_state <= c_st_run;
                end
                c_st_run: begin
                    // Stepping on every handshake, including the last, leaves
                    // the register one step past the final delivered word.
                    if (w_handshake) begin
                        r_lfsr       <= w_lfsr_next;
                        r_words_left <= r_words_left - c_one;
                        if (r_words_left == c_one) begin
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase

            // Abort overrides the state/count update but not the LFSR step,
            // so a coinciding final handshake still counts as delivered.
            if (w_abort) begin
                r_state      <= c_st_done;
                r_words_left <= '0;
            end
        end
    end

    assign bus.out_valid  = (r_state == c_st_run);
    assign bus.busy       = (r_state == c_st_load) || (r_state == c_st_run);
    assign bus.done       = (r_state == c_st_done);
    assign bus.lfsr_out   = r_lfsr;
    assign bus.words_left = r_words_left;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_burst_ctrl.sv
// ============================================================================
// Module      : tb_lfsr_burst_ctrl
// Description : Self-checking bench for lfsr_burst_ctrl. Expected words are
//               queued when a burst is requested and popped on each
//               handshake; latency, done count and end state are checked
//               after every burst. Abort cases are built only when
//               LFSR_BURST_CTRL_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_burst_ctrl;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    lfsr_burst_ctrl_if #(.LEN_W(LEN_W)) bus ();

    lfsr_burst_ctrl #(
        .LEN_W        (LEN_W),
        .DEFAULT_SEED (16'hACE1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          first_valid_cyc = -1;
    logic [15:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_word = 16'h0000;
    logic [15:0] m_lfsr = 16'h0000;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock: sample/score at negedge, then advance past the rising edge.
    task automatic step();
        @(negedge clk);
        if (reset_n === 1'b1) begin
            if (prev_stall)
                chk("stall_hold", {15'b0, bus.out_valid, bus.lfsr_out}, {16'h0001, prev_word});
            if (bus.out_valid === 1'b1 && first_valid_cyc < 0)
                first_valid_cyc = cyc;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0)
                    chk("extra_word", 32'(exp_q.size()), 32'd1);
                else
                    chk("word", {16'h0, bus.lfsr_out}, {16'h0, exp_q.pop_front()});
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            prev_word  = bus.lfsr_out;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_burst(input logic [15:0] sd, input int len, input logic [31:0] rdy_pat,
                             input bit mid_start, input int exp_lat);
        logic [15:0] s;
        int          d0;
        int          start_edge;
        int          k;
        s = (sd == 16'h0000) ? 16'hACE1 : sd;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(s);
            s = lfsr_step(s);
        end
        if (len != 0) m_lfsr = s;
        d0 = done_cnt;
        first_valid_cyc = -1;
        done_cyc = -1;
        bus.start     = 1'b1;
        bus.seed      = sd;
        bus.burst_len = LEN_W'(len);
        bus.out_ready = 1'b1;
        step();
        bus.start  = 1'b0;
        start_edge = cyc;
        k = 0;
        while (done_cnt == d0 && k < 100) begin
            bus.out_ready = (k < 32) ? rdy_pat[k] : 1'b1;
            if (mid_start && k == 2) begin
                bus.start     = 1'b1;
                bus.seed      = 16'h1234;
                bus.burst_len = LEN_W'(7);
            end
            step();
            bus.start = 1'b0;
            k++;
        end
        bus.out_ready = 1'b1;
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        chk("done_latency", 32'(done_cyc - start_edge), 32'(exp_lat));
        if (len != 0)
            chk("first_valid_latency", 32'(first_valid_cyc - start_edge), 32'd1);
        else
            chk("no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_lfsr", {16'h0, bus.lfsr_out}, {16'h0, m_lfsr});
        chk("words_left_end", 32'(bus.words_left), 32'd0);
        chk("busy_after", 32'(bus.busy), 32'd0);
        step();
        chk("single_done", 32'(done_cnt - d0), 32'd1);
        exp_q.delete();
    endtask

    initial begin
        int          d0;
        logic [15:0] s;

        // Reset with start held high: nothing may start or pulse.
        reset_n       = 1'b0;
        bus.start     = 1'b1;
        bus.seed      = 16'h1234;
        bus.burst_len = LEN_W'(5);
        bus.out_ready = 1'b1;
`ifdef LFSR_BURST_CTRL_ABORT_EN
        bus.abort     = 1'b0;
`endif
        step();
        step();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_words_left", 32'(bus.words_left), 32'd0);
        chk("rst_lfsr", {16'h0, bus.lfsr_out}, 32'h0);
        bus.start = 1'b0;
        reset_n   = 1'b1;
        step();
        chk("idle_after_rst", 32'(bus.busy), 32'd0);
        chk("no_done_after_rst", 32'(done_cnt), 32'd0);

        // Plain bursts, ready held high.
        run_burst(16'h0001, 4, 32'hFFFF_FFFF, 1'b0, 5);
        run_burst(16'h8000, 2, 32'hFFFF_FFFF, 1'b0, 3);
        run_burst(16'h0000, 1, 32'hFFFF_FFFF, 1'b0, 2);

        // Backpressure 1,0,0,1,1 on the valid cycles, start pulsed mid-burst.
        run_burst(16'h0001, 3, 32'hFFFF_FFF3, 1'b1, 6);

        // Empty burst: done one cycle after start, LFSR untouched.
        run_burst(16'h5555, 0, 32'hFFFF_FFFF, 1'b0, 0);

        // Reset mid-burst with five words still outstanding.
        s = 16'hC3A5;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(s);
            s = lfsr_step(s);
        end
        d0 = done_cnt;
        bus.start     = 1'b1;
        bus.seed      = 16'hC3A5;
        bus.burst_len = LEN_W'(8);
        bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mid_words_left", 32'(bus.words_left), 32'd5);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_words_left", 32'(bus.words_left), 32'd0);
        chk("mid_rst_lfsr", {16'h0, bus.lfsr_out}, 32'h0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) step();
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        m_lfsr = 16'h0000;

`ifdef LFSR_BURST_CTRL_ABORT_EN
        // Abort after three handshakes of a ten-word burst.
        s = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(s);
            s = lfsr_step(s);
        end
        m_lfsr = s;
        d0 = done_cnt;
        bus.start     = 1'b1;
        bus.seed      = 16'hBEEF;
        bus.burst_len = LEN_W'(10);
        bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        bus.out_ready = 1'b0;
        bus.abort     = 1'b1;
        step();
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        prev_stall    = 1'b0;
        chk("abort_words_left", 32'(bus.words_left), 32'd0);
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd1);
        step();
        step();
        chk("abort_single_done", 32'(done_cnt - d0), 32'd1);
        chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("abort_lfsr", {16'h0, bus.lfsr_out}, {16'h0, m_lfsr});

        // Abort coinciding with the final handshake.
        s = 16'h00FF;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(s);
            s = lfsr_step(s);
        end
        m_lfsr = s;
        d0 = done_cnt;
        bus.start     = 1'b1;
        bus.seed      = 16'h00FF;
        bus.burst_len = LEN_W'(2);
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_last_done", 32'(bus.done), 32'd1);
        step();
        step();
        chk("abort_last_single_done", 32'(done_cnt - d0), 32'd1);
        chk("abort_last_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("abort_last_lfsr", {16'h0, bus.lfsr_out}, {16'h0, m_lfsr});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
